lpc_record_packer: RTL

//  Stage downstream of the LPC cycle decoder. It captures each completed I/O read

---
 rtl/lpc_pkg.sv | 64 ++++++
 rtl/lpc_record_fifo.sv | 66 ++++++
 rtl/lpc_record_packer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpc_pkg : record layout, frame byte helpers and serializer state encoding  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lpc_pkg;

  localparam int unsigned CTD_W  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned REC_W  = 1 + CTD_W + ADDR_W + DATA_W;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  typedef struct packed {
    logic              sync_timeout;
    logic [CTD_W-1:0]  cyctype_dir;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lpc_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4,
    ST_B4   = 3'd5
  } ser_state_e;

  function automatic lpc_rec_t pack_record(
    input logic              timeout,
    input logic [CTD_W-1:0]  ctd,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    lpc_rec_t rec;
    rec.sync_timeout = timeout;
    rec.cyctype_dir  = ctd;
    rec.addr         = addr;
    rec.data         = data;
    return rec;
  endfunction

  // Byte idx of the 5-byte frame built from a record; idx 0 is the header.
  function automatic logic [7:0] frame_byte(
    input lpc_rec_t   rec,
    input logic [2:0] idx,
    input logic [7:0] hdr
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = {3'b000, rec.sync_timeout, rec.cyctype_dir};
      3'd2:    b = rec.addr[15:8];
      3'd3:    b = rec.addr[7:0];
      3'd4:    b = rec.data;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_record_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpc_record_fifo : single-clock show-ahead FIFO with push/pop/full/empty    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lpc_record_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = empty_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/lpc_record_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpc_record_packer : buffers LPC I/O read records, emits 5-byte frames      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lpc_record_packer
  import lpc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEFAULT
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic        in_sync_timeout,
  input  logic        in_clock_enable,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_overflow_cnt,
  output logic        out_fifo_empty
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic           ce_q, ce_d;
  ser_state_e     state_q, state_d;
  lpc_rec_t       hold_q, hold_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic [7:0]     ovf_q, ovf_d;

  logic           push_req;
  logic           fifo_pop;
  lpc_rec_t       rec_in;
  logic [REC_W-1:0] fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count_unused;
  logic           addr_hi_unused;

  assign addr_hi_unused = ^in_addr[31:16];

  lpc_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (lpc_clock),
    .rst_n (lpc_reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (rec_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  always_comb begin
    ce_d     = in_clock_enable;
    push_req = in_clock_enable & ~ce_q;
    rec_in   = pack_record(in_sync_timeout, in_cyctype_dir, in_addr[15:0], in_data);

    ovf_d = ovf_q;
    if (push_req && fifo_full && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end

    state_d  = state_q;
    hold_d   = hold_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = lpc_rec_t'(fifo_rdata);
          byte_d   = HDR_BYTE;
          valid_d  = 1'b1;
          state_d  = ST_B0;
        end
      end
      ST_B0: if (out_ready) begin
        byte_d  = frame_byte(hold_q, 3'd1, HDR_BYTE);
        state_d = ST_B1;
      end
      ST_B1: if (out_ready) begin
        byte_d  = frame_byte(hold_q, 3'd2, HDR_BYTE);
        state_d = ST_B2;
      end
      ST_B2: if (out_ready) begin
        byte_d  = frame_byte(hold_q, 3'd3, HDR_BYTE);
        state_d = ST_B3;
      end
      ST_B3: if (out_ready) begin
        byte_d  = frame_byte(hold_q, 3'd4, HDR_BYTE);
        state_d = ST_B4;
      end
      ST_B4: if (out_ready) begin
        // Chain straight into the next frame so valid never drops between frames.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = lpc_rec_t'(fifo_rdata);
          byte_d   = HDR_BYTE;
          state_d  = ST_B0;
        end else begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      ce_q    <= 1'b0;
      state_q <= ST_IDLE;
      hold_q  <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 8'h00;
    end else begin
      ce_q    <= ce_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_byte         = byte_q;
  assign out_valid        = valid_q;
  assign out_overflow_cnt = ovf_q;
  assign out_fifo_empty   = fifo_empty;

endmodule
`default_nettype wire
